// File: rtl/sb_pkg.sv
// Shared constants and source-selection arithmetic for the parameterised switch box.
package sb_pkg;

    localparam int CFG_WORD_W = 32;
    localparam int NUM_SIDES  = 4;

    // Select codes: values 0..2 pick the k=1..3 track source, 3.. pick PE outputs.
    localparam int SEL_K1  = 0;
    localparam int SEL_K2  = 1;
    localparam int SEL_K3  = 2;
    localparam int SEL_PE0 = 3;

    typedef struct packed {
        int side;
        int track;
    } sb_src_t;

    // Source for output (s,t) under code k: side (s+k) mod 4, track rotated by that side.
    function automatic sb_src_t sb_src(input int s, input int t, input int k, input int nt);
        sb_src_t r;
        r.side  = (s + k) % NUM_SIDES;
        r.track = (t + r.side + nt - 1) % nt;
        return r;
    endfunction

endpackage

// File: rtl/sb_param_switch_if.sv
// Configuration bus of the switch box: shadow writes, commit strobe, readback.
interface sb_param_switch_if;

    logic                          cfg_wr_en;
    logic [7:0]                    cfg_addr;
    logic [sb_pkg::CFG_WORD_W-1:0] cfg_wr_data;
    logic                          cfg_commit;
    logic                          cfg_rd_en;
    logic [sb_pkg::CFG_WORD_W-1:0] cfg_rd_data;
    logic                          cfg_rd_valid;
    logic                          cfg_err;

    modport master (
        output cfg_wr_en, cfg_addr, cfg_wr_data, cfg_commit, cfg_rd_en,
        input  cfg_rd_data, cfg_rd_valid, cfg_err
    );

    modport slave (
        input  cfg_wr_en, cfg_addr, cfg_wr_data, cfg_commit, cfg_rd_en,
        output cfg_rd_data, cfg_rd_valid, cfg_err
    );

endinterface

// File: rtl/sb_track_mux.sv
// One output track: select among three track sources and the PE outputs,
// optionally through an output register.
module sb_track_mux
    import sb_pkg::*;
#(
    parameter int WIDTH  = 1,
    parameter int NUM_PE = 1,
    parameter int SEL_W  = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [SEL_W-1:0]        sel_i,
    input  logic                    reg_mode_i,
    input  logic [3*WIDTH-1:0]      trk_i,
    input  logic [NUM_PE*WIDTH-1:0] pe_i,
    output logic [WIDTH-1:0]        out_o
);

    logic [WIDTH-1:0] mux_d;
    logic [WIDTH-1:0] out_q;

    // Source mux; codes past the last PE drive zero.
    always_comb begin
        mux_d = '0;
        for (int k = 0; k < 3; k++)
            if (int'(sel_i) == SEL_K1 + k) mux_d = trk_i[k*WIDTH +: WIDTH];
        for (int p = 0; p < NUM_PE; p++)
            if (int'(sel_i) == SEL_PE0 + p) mux_d = pe_i[p*WIDTH +: WIDTH];
    end

    // Output register captures every cycle so a mode switch sees current data.
    always_ff @(posedge clk) begin
        if (reset) out_q <= '0;
        else       out_q <= mux_d;
    end

    assign out_o = reg_mode_i ? out_q : mux_d;

endmodule

// File: rtl/sb_param_switch.sv
// Parameterised switch box: 4 sides x NUM_TRACKS tracks, double-buffered
// select/mode configuration with commit and readback.
module sb_param_switch
    import sb_pkg::*;
#(
    parameter int NUM_TRACKS = 4,
    parameter int WIDTH      = 1,
    parameter int NUM_PE     = 1
) (
    input  logic                             clk,
    input  logic                             reset,
    sb_param_switch_if.slave                 cfg,
    input  logic [4*NUM_TRACKS*WIDTH-1:0]    in_wires,
    input  logic [NUM_PE*WIDTH-1:0]          pe_out,
    output logic [4*NUM_TRACKS*WIDTH-1:0]    out_wires
);

    localparam int SEL_W         = $clog2(3 + NUM_PE);
    localparam int FPW           = CFG_WORD_W / SEL_W;
    localparam int NUM_OUT       = NUM_SIDES * NUM_TRACKS;
    localparam int NUM_SEL_WORDS = (NUM_OUT + FPW - 1) / FPW;
    localparam int MASK_ADDR     = NUM_SEL_WORDS;
    localparam int NUM_WORDS     = MASK_ADDR + 1;

    if (NUM_OUT > CFG_WORD_W) begin : g_bad_cfg
        $error("sb_param_switch: NUM_OUT above 32 has no room in the mode mask word");
    end

    logic [NUM_WORDS-1:0][CFG_WORD_W-1:0] shadow_q;
    logic [NUM_WORDS-1:0][CFG_WORD_W-1:0] active_q;
    logic [CFG_WORD_W-1:0]                rd_data_q, rd_data_d;
    logic                                 rd_valid_q;
    logic                                 err_q;
    logic                                 addr_oor;

    assign addr_oor = cfg.cfg_addr > 8'(MASK_ADDR);

    // Readback word from the active bank; out-of-range addresses read zero.
    always_comb begin
        rd_data_d = '0;
        for (int w = 0; w < NUM_WORDS; w++)
            if (cfg.cfg_addr == 8'(w)) rd_data_d = active_q[w];
    end

    // Config state: commit copies the pre-write shadow, so a same-cycle
    // write stays pending for the next commit.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_q   <= '0;
            active_q   <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            for (int w = 0; w < NUM_WORDS; w++)
                if (cfg.cfg_wr_en && cfg.cfg_addr == 8'(w)) shadow_q[w] <= cfg.cfg_wr_data;
            if (cfg.cfg_commit) active_q <= shadow_q;
            rd_valid_q <= cfg.cfg_rd_en;
            if (cfg.cfg_rd_en) rd_data_q <= rd_data_d;
            if ((cfg.cfg_wr_en || cfg.cfg_rd_en) && addr_oor) err_q <= 1'b1;
        end
    end

    assign cfg.cfg_rd_data  = rd_data_q;
    assign cfg.cfg_rd_valid = rd_valid_q;
    assign cfg.cfg_err      = err_q;

    for (genvar o = 0; o < NUM_OUT; o++) begin : g_out
        localparam int S = o / NUM_TRACKS;
        localparam int T = o % NUM_TRACKS;
        logic [3*WIDTH-1:0] trk;

        for (genvar k = 1; k <= 3; k++) begin : g_src
            localparam sb_src_t SRC = sb_src(S, T, k, NUM_TRACKS);
            localparam int      IDX = SRC.side * NUM_TRACKS + SRC.track;
            assign trk[(k-1)*WIDTH +: WIDTH] = in_wires[IDX*WIDTH +: WIDTH];
        end

        sb_track_mux #(
            .WIDTH  (WIDTH),
            .NUM_PE (NUM_PE),
            .SEL_W  (SEL_W)
        ) u_mux (
            .clk        (clk),
            .reset      (reset),
            .sel_i      (active_q[o/FPW][(o%FPW)*SEL_W +: SEL_W]),
            .reg_mode_i (active_q[MASK_ADDR][o]),
            .trk_i      (trk),
            .pe_i       (pe_out),
            .out_o      (out_wires[o*WIDTH +: WIDTH])
        );
    end

endmodule

// File: tb/tb_sb_param_switch.sv
// Directed + randomized bench for sb_param_switch (4 tracks, 1-bit, 1 PE).
module tb_sb_param_switch;

    localparam int NT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] in_wires;
    logic [0:0]  pe_out;
    logic [15:0] out_wires;

    always #5 clk = ~clk;

    sb_param_switch_if cfg_if();

    sb_param_switch #(.NUM_TRACKS(NT), .WIDTH(1), .NUM_PE(1)) dut (
        .clk       (clk),
        .reset     (reset),
        .cfg       (cfg_if),
        .in_wires  (in_wires),
        .pe_out    (pe_out),
        .out_wires (out_wires)
    );

    // Reference state: shadow/active banks, last captured route, readback, error.
    logic [31:0] sh [2];
    logic [31:0] ac [2];
    logic [15:0] regm;
    logic        m_rdv;
    logic [31:0] m_rdd;
    logic        m_err;
    int n_chk = 0, n_pass = 0, n_fail = 0;

    // Routing straight from the rules: code v<3 -> k=v+1, side (s+k)%4,
    // track (t+side+3)%4; code 3 -> PE output 0.
    function automatic logic [15:0] route(input logic [31:0] selw, input logic [15:0] inw, input logic pe);
        logic [15:0] r;
        for (int o = 0; o < 16; o++) begin
            int s = o / 4;
            int t = o % 4;
            int v = int'((selw >> (2*o)) & 32'd3);
            if (v == 3) r[o] = pe;
            else begin
                int q  = (s + v + 1) % 4;
                int tr = (t + q + 3) % 4;
                r[o] = inw[q*4 + tr];
            end
        end
        return r;
    endfunction

    function automatic logic [15:0] exp_out();
        logic [15:0] c = route(ac[0], in_wires, pe_out[0]);
        logic [15:0] r;
        for (int o = 0; o < 16; o++) r[o] = ac[1][o] ? regm[o] : c[o];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Advance one clock, updating the model with whatever is driven now.
    task automatic tick();
        if (reset) begin
            sh[0] = 0; sh[1] = 0; ac[0] = 0; ac[1] = 0;
            regm = 0; m_rdv = 0; m_rdd = 0; m_err = 0;
        end else begin
            regm  = route(ac[0], in_wires, pe_out[0]);
            m_rdv = cfg_if.cfg_rd_en;
            if (cfg_if.cfg_rd_en)
                m_rdd = (cfg_if.cfg_addr <= 8'd1) ? ac[cfg_if.cfg_addr[0]] : 32'h0;
            if ((cfg_if.cfg_wr_en || cfg_if.cfg_rd_en) && cfg_if.cfg_addr > 8'd1) m_err = 1'b1;
            if (cfg_if.cfg_commit) begin ac[0] = sh[0]; ac[1] = sh[1]; end
            if (cfg_if.cfg_wr_en && cfg_if.cfg_addr <= 8'd1) sh[cfg_if.cfg_addr[0]] = cfg_if.cfg_wr_data;
        end
        @(posedge clk);
        #1;
        cfg_if.cfg_wr_en  = 1'b0;
        cfg_if.cfg_commit = 1'b0;
        cfg_if.cfg_rd_en  = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic cm);
        cfg_if.cfg_wr_en = 1'b1; cfg_if.cfg_addr = a; cfg_if.cfg_wr_data = d; cfg_if.cfg_commit = cm;
        tick();
    endtask

    task automatic commit();
        cfg_if.cfg_commit = 1'b1;
        tick();
    endtask

    task automatic rd(input string tag, input logic [7:0] a, input logic [31:0] expv);
        cfg_if.cfg_rd_en = 1'b1; cfg_if.cfg_addr = a;
        tick();
        chk({tag, "_valid"}, 32'(cfg_if.cfg_rd_valid), 32'd1);
        chk({tag, "_data"}, cfg_if.cfg_rd_data, expv);
    endtask

    task automatic rand_in();
        in_wires = 16'($urandom);
        pe_out   = 1'($urandom);
        #1;
    endtask

    task automatic chk_out(input string tag);
        chk(tag, 32'(out_wires), 32'(exp_out()));
    endtask

    initial begin
        logic prev4;
        reset = 1'b1;
        in_wires = 16'h0; pe_out = 1'b0;
        cfg_if.cfg_wr_en = 1'b0; cfg_if.cfg_addr = 8'h0; cfg_if.cfg_wr_data = 32'h0;
        cfg_if.cfg_commit = 1'b0; cfg_if.cfg_rd_en = 1'b0;
        tick(); tick();
        reset = 1'b0;

        // Reset routing: every output on its k=1 source.
        in_wires = 16'hA5C3; #1;
        chk_out("reset_route");
        chk("reset_side0", 32'(out_wires[3:0]), 32'h0000000C);
        chk("reset_err", 32'(cfg_if.cfg_err), 32'd0);
        chk("reset_rdv", 32'(cfg_if.cfg_rd_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin rand_in(); chk_out("default_rand"); tick(); end

        // Shadow write alone changes nothing; commit moves everything to PE.
        wr(8'd0, 32'hFFFF_FFFF, 1'b0);
        rand_in(); chk_out("shadow_only");
        commit();
        pe_out = 1'b0; #1; chk("pe_follow_0", 32'(out_wires), 32'h0000_0000);
        pe_out = 1'b1; #1; chk("pe_follow_1", 32'(out_wires), 32'h0000_FFFF);

        // Output 0 registered, all selects back to code 0.
        wr(8'd1, 32'h0000_0001, 1'b0);
        wr(8'd0, 32'h0000_0000, 1'b0);
        commit();
        for (int i = 0; i < 8; i++) begin
            rand_in();
            chk_out("reg_mode");
            if (i > 0) chk("reg_latency", 32'(out_wires[0]), 32'(prev4));
            prev4 = in_wires[4];
            tick();
        end
        wr(8'd1, 32'h0, 1'b1);
        commit();

        // Write colliding with commit: commit takes the old shadow.
        wr(8'd0, 32'h5555_5555, 1'b1);
        rand_in(); chk_out("collide_old");
        rd("collide_rd", 8'd0, 32'h0);
        commit();
        rand_in(); chk_out("collide_new");
        chk("k2_route", 32'(out_wires[0]), 32'(in_wires[9]));
        rd("commit_rd", 8'd0, 32'h5555_5555);

        // Out-of-range read: zero data, sticky error.
        rd("oor_rd", 8'd5, 32'h0);
        chk("oor_err", 32'(cfg_if.cfg_err), 32'd1);
        wr(8'd7, 32'hDEAD_BEEF, 1'b1);
        rand_in(); chk_out("oor_wr_ignored");
        chk("err_sticky", 32'(cfg_if.cfg_err), 32'd1);

        // Randomized config traffic against the model.
        for (int i = 0; i < 40; i++) begin
            rand_in();
            chk_out("rand_route");
            cfg_if.cfg_wr_en   = 1'($urandom);
            cfg_if.cfg_addr    = 8'($urandom_range(0, 2));
            cfg_if.cfg_wr_data = (cfg_if.cfg_addr == 8'd1) ? 32'($urandom_range(0, 65535)) : $urandom;
            cfg_if.cfg_commit  = ($urandom_range(0, 3) == 0);
            cfg_if.cfg_rd_en   = ($urandom_range(0, 2) == 0);
            tick();
            chk("rand_rdv", 32'(cfg_if.cfg_rd_valid), 32'(m_rdv));
            if (m_rdv) chk("rand_rdd", cfg_if.cfg_rd_data, m_rdd);
            chk("rand_err", 32'(cfg_if.cfg_err), 32'(m_err));
        end

        // Reset after a shadow write discards it.
        wr(8'd0, 32'hFFFF_FFFF, 1'b0);
        reset = 1'b1; tick(); reset = 1'b0;
        commit();
        in_wires = 16'hA5C3; #1;
        chk_out("post_reset_route");
        chk("post_reset_side0", 32'(out_wires[3:0]), 32'h0000000C);
        chk("post_reset_err", 32'(cfg_if.cfg_err), 32'd0);
        rd("post_reset_rd", 8'd0, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sb_param_switch.md
SB_PARAM_SWITCH -- requirements
Module: sb_param_switch

Interface
REQ-001 Parameter NUM_TRACKS, default 4: tracks per side; 4 sides fixed (0..3).
REQ-002 Parameter WIDTH, default 1: bits per track.
REQ-003 Parameter NUM_PE, default 1: PE outputs selectable onto any track.
REQ-004 Derived SEL_W = clog2(3+NUM_PE); FPW = floor(32/SEL_W) fields per word; NUM_OUT = 4*NUM_TRACKS; NUM_SEL_WORDS = ceil(NUM_OUT/FPW); MASK_ADDR = NUM_SEL_WORDS.
REQ-005 clk  in  1  clock; reset reset, synchronous, active-high; clock clk.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 in_wires  in  NUM_OUT*WIDTH  flattened; track (s,t) at index (s*NUM_TRACKS+t)*WIDTH.
REQ-008 pe_out  in  NUM_PE*WIDTH  PE outputs, same flattening.
REQ-009 out_wires  out  NUM_OUT*WIDTH  routed tracks, same flattening.
REQ-010 cfg_wr_en, cfg_addr[7:0], cfg_wr_data[31:0]  in  single-cycle write strobe, word address, data.
REQ-011 cfg_commit  in  1  pulse: shadow config becomes active.
REQ-012 cfg_rd_en  in  1; cfg_rd_data  out  32; cfg_rd_valid  out  1  readback of active config.
REQ-013 cfg_err  out  1  sticky: write or read to address > MASK_ADDR.

Function
REQ-014 Output (s,t), code k in 1..3 (select value k-1): source side q=(s+k) mod 4, track (t+q+NUM_TRACKS-1) mod NUM_TRACKS.
REQ-015 Select values 3..3+NUM_PE-1 choose pe_out[value-3]; values above that drive all-zero.
REQ-016 Output o=s*NUM_TRACKS+t uses field o: word o/FPW, bits [(o%FPW)*SEL_W +: SEL_W]; unused upper bits ignored.
REQ-017 Word MASK_ADDR bit o (o<32; NUM_OUT>32 unsupported, elaboration error) selects output mode: 0 combinational, 1 registered (one clk latency).
REQ-018 Writes land in shadow registers only, at the clock edge where cfg_wr_en=1; routing unaffected until commit.
REQ-019 cfg_commit=1 copies all shadow words (select and mask) into active registers at that edge; new routing visible the following cycle.
REQ-020 cfg_wr_en and cfg_commit in the same cycle: commit copies pre-write shadow; write remains pending in shadow for next commit.
REQ-021 Registered-mode output register captures mux result every cycle; mode change on commit takes effect cycle after commit, register content not cleared.
REQ-022 cfg_rd_en=1: next cycle cfg_rd_valid=1, cfg_rd_data=active word at cfg_addr (zero if out of range); otherwise cfg_rd_valid=0.
REQ-023 Out-of-range write ignored; out-of-range read or write sets cfg_err, held until reset.

Reset
REQ-024 Reset clears shadow, active, mask, output registers, cfg_rd_valid, cfg_rd_data, cfg_err to zero.
REQ-025 After reset every output is combinational with select 0, i.e. equal to its k=1 source.
REQ-026 Reset asserted mid-sequence discards uncommitted shadow writes; reset dominates simultaneous write/commit.

Structure
REQ-027 Package sb_pkg holds CFG_WORD_W=32, select-code constants, and function computing source side/track from (s,t,k,NUM_TRACKS).
REQ-028 One sub-module sb_track_mux: one output's mux plus optional output register, instantiated NUM_OUT times by generate.

Verification (NUM_TRACKS=4, WIDTH=1, NUM_PE=1: SEL_W=2, FPW=16, MASK_ADDR=1)
REQ-029 Reset, in_wires=16'hA5C3 -> each output equals its k=1 source; out_wires bits 0..3 = in_wires bits 4..7; cfg_err=0.
REQ-030 Write addr0=32'hFFFF_FFFF, no commit -> routing unchanged; commit -> next cycle all outputs track pe_out (toggle 0/1, follows same cycle).
REQ-031 Write addr1=32'h0000_0001, commit, addr0=0 -> out_wires[0] follows in_wires[4] one cycle late; other outputs zero-latency.
REQ-032 Same-cycle write addr0=32'h5555_5555 and commit -> active stays old value; second commit -> active=32'h5555_5555 (out (0,0)=in (2,1)).
REQ-033 Read addr0 after commit -> cfg_rd_valid one cycle after cfg_rd_en, data=committed word; read addr 5 -> data 0, cfg_err=1 until reset.
REQ-034 Reset asserted one cycle after shadow write, then commit -> active all zero, REQ-029 routing restored.
